// File: rtl/fdiv_share_pkg.sv
// Shared types and defaults for the FP divide-unit sharing controller.
package fdiv_share_pkg;

  localparam int FP_W        = 32;
  localparam int NREQ_DEF    = 2;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fdiv_share_ctrl_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, in cyclic order.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int cand;

  // Walk from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (cand < NREQ && req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand[IDX_W-1:0];
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdiv_share_ctrl.sv
// Shares one multi-cycle FP divider between NREQ requesters with round-robin
// arbitration, start/done sequencing and a watchdog timeout.
//
//   state | meaning
//   IDLE  | waiting for a request while the divider is quiet
//   ISSUE | div_start high, operands presented
//   WAIT  | waiting for div_done, watchdog running
//   RESP  | rsp_valid pulse to the owner
module fdiv_share_ctrl
  import fdiv_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [FP_W*NREQ-1:0] req_a,
  input  logic [FP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 ctrl_busy,
  output logic                 div_start,
  output logic [FP_W-1:0]      div_a,
  output logic [FP_W-1:0]      div_b,
  input  logic [FP_W-1:0]      div_result,
  input  logic                 div_busy,
  input  logic                 div_done
);

  localparam int IDX_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [FP_W-1:0]  op_a, op_b;
  logic [IDX_W-1:0] owner, rr_ptr;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             expire;
  logic             accept;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  logic [FP_W-1:0]  sel_a, sel_b;
  logic [NREQ-1:0]  owner_oh;
  logic [IDX_W-1:0] ptr_after;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        // Holding off while busy/done guarantees the divider is idle at start.
        if (found && !div_busy && !div_done && !rst) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_done || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = accept ? grant : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) owner_oh[i] = (int'(owner) == i);
  end

  assign ptr_after = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDX_W'(1);

  // Expiry fires on the cycle the counter steps onto TIMEOUT-1.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign expire  = (cnt_inc == CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ctrl_busy <= 1'b0;
      div_start <= 1'b0;
    end else begin
      ctrl_busy <= (state_nxt != IDLE);
      div_start <= accept;
      rsp_valid <= '0;
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        owner  <= grant_idx;
        rr_ptr <= ptr_after;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt_inc;
      if (state == WAIT) begin
        if (div_done) begin
          rsp_data  <= div_result;
          rsp_err   <= 1'b0;
          rsp_valid <= owner_oh;
        end else if (expire) begin
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= owner_oh;
        end
      end
    end
  end

  assign div_a = op_a;
  assign div_b = op_b;

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// Randomized bench for fdiv_share_ctrl against a transaction-timeline model
// and a simple variable-latency divider stand-in.
module tb_fdiv_share_ctrl;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;
  localparam int HANG    = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid;
  logic [32*NREQ-1:0]   req_a, req_b;
  logic [31:0]          rsp_data, div_a, div_b, div_result;
  logic                 rsp_err, ctrl_busy, div_start, div_busy, div_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model of the controller's transaction timeline
  bit          m_active = 0;
  int          m_T = 0, m_R = 0, m_owner = 0, m_ptr = 0;
  logic [31:0] m_a, m_b, m_data;
  logic        m_err;
  int          accepts = 0;

  // divider stand-in
  int          d_S = -1000, d_L = 0, pend_L = 0;
  logic [31:0] d_a = '0, d_b = '0;

  int force_L    = -2;  // -2 random, -1 never done, >=0 fixed busy length
  int drive_mode = 0;   // 0 preset, 1 all valid, 2 random valid

  always #5 clk = ~clk;

  fdiv_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ctrl_busy(ctrl_busy), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .div_busy(div_busy), .div_done(div_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int first_from(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int pick_L();
    int r;
    if (force_L != -2) return force_L;
    r = int'($urandom_range(0, 9));
    return (r < 7) ? r : -1;
  endfunction

  // one clock cycle, entered and left just after a falling edge
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    bit in_txn;
    int g, D;
    in_txn = m_active && cyc > m_T && cyc <= m_R;
    check("div_start", div_start, m_active && cyc == m_T + 1);
    check("ctrl_busy", ctrl_busy, in_txn);
    check("rsp_valid", rsp_valid, (m_active && cyc == m_R) ? onehot(m_owner) : '0);
    if (m_active && cyc == m_R) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_err", rsp_err, m_err);
    end
    if (in_txn) begin
      check("div_a", div_a, m_a);
      check("div_b", div_b, m_b);
    end

    if (div_start) begin d_S = cyc; d_L = pend_L; end
    if (cyc == d_S + 1) begin d_a = div_a; d_b = div_b; end
    div_busy   = (cyc > d_S) && ((d_L < 0) ? (cyc <= d_S + HANG) : (cyc <= d_S + d_L));
    div_done   = (d_L >= 0) && (cyc == d_S + d_L + 1);
    div_result = div_done ? fake_div(d_a, d_b) : $urandom;

    if (drive_mode == 1) req_valid = '1;
    if (drive_mode == 2) req_valid = NREQ'($urandom);
    if (drive_mode != 0)
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
      end
    #1;
    exp_ready = '0;
    g = -1;
    if ((!m_active || cyc > m_R) && (|req_valid) && !div_busy && !div_done) begin
      g = first_from(req_valid, m_ptr);
      exp_ready = onehot(g);
    end
    check("req_ready", req_ready, exp_ready);
    if (g >= 0) begin
      accepts++;
      m_active = 1;
      m_T      = cyc;
      m_owner  = g;
      m_a      = req_a[g*32 +: 32];
      m_b      = req_b[g*32 +: 32];
      m_ptr    = (g + 1) % NREQ;
      pend_L   = pick_L();
      D        = m_T + 2 + pend_L;
      if (pend_L >= 0 && D <= m_T + TIMEOUT) begin
        m_R = D + 1; m_data = fake_div(m_a, m_b); m_err = 1'b0;
      end else begin
        m_R = m_T + 1 + TIMEOUT; m_data = '0; m_err = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_ctrl_busy", ctrl_busy, 1'b0);
    check("rst_div_start", div_start, 1'b0);
    check("rst_div_a", div_a, '0);
    check("rst_div_b", div_b, '0);
    m_active = 0; m_ptr = 0;
    d_S = -1000; d_L = 0;
    div_busy = 1'b0; div_done = 1'b0;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit hit;
    int seen;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    div_busy = 1'b0; div_done = 1'b0; div_result = '0;
    @(negedge clk);
    check("init_req_ready", req_ready, '0);
    check("init_rsp_valid", rsp_valid, '0);
    check("init_rsp_data", rsp_data, '0);
    check("init_ctrl_busy", ctrl_busy, 1'b0);
    check("init_div_start", div_start, 1'b0);
    check("init_div_a", div_a, '0);
    @(negedge clk);
    rst = 1'b0;

    // single request from requester 0: 6.0 / 2.0
    drive_mode = 0; force_L = 3;
    req_valid = 2'b01;
    req_a = {32'h0, 32'h40C00000};
    req_b = {32'h0, 32'h40000000};
    seen = accepts;
    for (int i = 0; i < 5 && accepts == seen; i++) step();
    check("single_accepted", accepts - seen, 1);
    req_valid = '0;
    repeat (12) step();

    // contention: both requesters always valid
    drive_mode = 1; force_L = -2;
    for (int i = 0; i < 80; i++) begin
      force_L = int'($urandom_range(0, 5));
      step();
    end

    // divider never completes -> watchdog responses
    force_L = -1;
    repeat (40) step();

    // done coincides with the last watchdog cycle
    force_L = TIMEOUT - 2;
    repeat (40) step();

    // random traffic
    drive_mode = 2; force_L = -2;
    repeat (300) step();

    // drain, then reset in the middle of a WAIT
    drive_mode = 0; req_valid = '0;
    repeat (20) step();
    force_L = 5; req_valid = 2'b10;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_active && cyc == m_T + 4) hit = 1;
      else step();
    end
    check("reached_wait", hit, 1'b1);
    if (hit) begin
      req_valid = 2'b11;
      mid_reset();
      drive_mode = 1; force_L = 2;
      repeat (30) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
